hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Parametrised hazard and stall controller for the five-stage pipeline, replacing the single-cycle load-use detector. It detects load-use hazards on any number of source operands and inserts a configurable number of bubbles for multi-cycle load-to-use latency. It also freezes the whole pipeline while the data memory is not ready, flushes IF/ID and ID/EX on a taken branch, and keeps a saturating stall-cycle counter. It sits beside the ID stage; its outputs drive the PC, IF/ID, ID/EX and EX/MEM register enables and flushes.

## Interface
- REG_W, 5, register-index width
- NUM_SRC, 2, source operands checked per instruction in ID (rn, rm, …)
- LOAD_LAT, 1, bubbles required between a load and a dependent instruction (≥1)
- ZERO_REG, 31, register index that never creates a hazard
- CNT_W, 32, stall-counter width
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- idex_mem_read  in  1  instruction in ID/EX is a load
- idex_rd  in  REG_W  destination of ID/EX instruction
- ifid_src  in  NUM_SRC*REG_W  source indices of IF/ID instruction, operand k at [k*REG_W +: REG_W]
- ifid_src_valid  in  NUM_SRC  operand k is actually read
- branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  EX/MEM instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_write_en, ifid_write_en, idex_write_en, exmem_write_en  out  1 each  register enables
- ifid_flush, idex_flush  out  1 each  load NOP/bubble into that register
- stall_cycles  out  CNT_W  count of cycles with pc_write_en low

## Operation
- States: RUN, LOAD_STALL. A down-counter rem, $clog2(LOAD_LAT+1) bits, is valid in LOAD_STALL.
- hazard = idex_mem_read && idex_rd != ZERO_REG && ∃k: ifid_src_valid[k] && src[k]==idex_rd.
- mem_freeze = mem_req && !mem_ready. It has the highest priority, in any state:
  - all four write enables are 0, both flushes are 0;
  - state and rem hold;
  - the stall counter increments.
- RUN, no freeze, branch_taken:
  - pc_write_en=1, ifid_flush=1, idex_flush=1;
  - hazard is ignored;
  - stay in RUN.
- RUN, no freeze, hazard:
  - pc_write_en=0, ifid_write_en=0, idex_flush=1; idex/exmem enables are 1;
  - if LOAD_LAT>1, go to LOAD_STALL with rem=LOAD_LAT-1; otherwise stay in RUN.
- RUN, otherwise: all enables 1, flushes 0.
- LOAD_STALL, no freeze:
  - outputs are the same as a hazard stall; hazard is not re-evaluated;
  - rem decrements; when rem==1 this cycle, return to RUN.
- branch_taken in LOAD_STALL cannot legally occur, because EX holds a bubble. It is ignored and flagged by a bench assertion.
- Stall counter:
  - stall_cycles += 1 on every cycle with pc_write_en==0;
  - it saturates at all-ones and never wraps.
- Reset:
  - state=RUN, rem=0, stall_cycles=0;
  - during reset the outputs are all enables 1 and flushes 0;
  - reset asserted mid-stall aborts the stall on the next edge.

## Timing
- All control outputs are combinational from state, rem and the current inputs, so they take effect in the same cycle as the hazard. There is no added pipeline latency.
- A load-use hazard costs exactly LOAD_LAT stall cycles, excluding freeze cycles.
- A freeze extends the stall 1:1; the remaining bubbles resume after mem_ready.
- stall_cycles updates on the edge ending the stalled cycle and is visible the following cycle.
- Simultaneous hazard and branch_taken in RUN: the branch wins and no bubble counter starts.
- Simultaneous freeze and branch_taken: the freeze wins; the branch is acted on in the first unfrozen cycle, because EX is held.

## Structure
- Shared pipeline package holds:
  - the state enum (HZ_RUN, HZ_LOAD_STALL);
  - the ZERO_REG default constant;
  - a stage-control struct {write_en, flush} reused by other pipeline control blocks.
- One sub-module, hazard_src_match: a parametrised NUM_SRC comparator reducing to the hazard bit. Generate-loop compare with valid masking and zero-register exclusion.
- FSM, counter and stall_cycles live in the top module.

## Test plan
- LOAD_LAT=1: load to x3 in ID/EX, src0=3 valid → one cycle with pc_write_en=0, ifid_write_en=0, idex_flush=1; next cycle all enables 1; stall_cycles=1.
- LOAD_LAT=3: same hazard → exactly 3 stall cycles, then RUN; src=3 but ifid_src_valid=0 → no stall; idex_rd=31 matching src → no stall.
- NUM_SRC=3: match only on operand 2 → stall; idex_mem_read=0 with match → no stall.
- LOAD_LAT=3, mem_ready low for 2 cycles in the middle of the stall:
  - all enables 0 for those 2 cycles, rem held;
  - total 5 stalled cycles; stall_cycles=5.
- Hazard and branch_taken in the same cycle → pc_write_en=1, ifid_flush=idex_flush=1, no LOAD_STALL; reset asserted in LOAD_STALL → next cycle RUN, stall_cycles=0.
- CNT_W=4: hold a freeze for 20 cycles → stall_cycles saturates at 15 and stays there.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline-control types: hazard FSM states, the zero-register default
// and the per-stage {write_en, flush} bundle used by the pipeline control blocks.
package hazard_stall_ctrl_pkg;

   typedef enum logic {
      HZ_RUN        = 1'b0,
      HZ_LOAD_STALL = 1'b1
   } hz_state_e;

   localparam int ZERO_REG_DEFAULT = 31;

   typedef struct packed {
      logic write_en;
      logic flush;
   } stage_ctrl_t;

   localparam stage_ctrl_t STAGE_RUN = '{write_en: 1'b1, flush: 1'b0};

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall controller: hazard inputs from
// ID and ID/EX, memory handshake, and the register enables/flushes it drives.
interface hazard_stall_ctrl_if #(
   parameter int REG_W   = 5,
   parameter int NUM_SRC = 2,
   parameter int CNT_W   = 32
);
   logic                     idex_mem_read;
   logic [REG_W-1:0]         idex_rd;
   logic [NUM_SRC*REG_W-1:0] ifid_src;
   logic [NUM_SRC-1:0]       ifid_src_valid;
   logic                     branch_taken;
   logic                     mem_req;
   logic                     mem_ready;

   logic                     pc_write_en;
   logic                     ifid_write_en;
   logic                     idex_write_en;
   logic                     exmem_write_en;
   logic                     ifid_flush;
   logic                     idex_flush;
   logic [CNT_W-1:0]         stall_cycles;

   modport master (
      output idex_mem_read, idex_rd, ifid_src, ifid_src_valid,
             branch_taken, mem_req, mem_ready,
      input  pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
             ifid_flush, idex_flush, stall_cycles
   );

   modport slave (
      input  idex_mem_read, idex_rd, ifid_src, ifid_src_valid,
             branch_taken, mem_req, mem_ready,
      output pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
             ifid_flush, idex_flush, stall_cycles
   );
endinterface

// File: rtl/hazard_stall_ctrl_src_match.sv
// Load-use comparator: flags a hazard when any valid ID source operand names
// the destination of the load sitting in ID/EX (the zero register never counts).
module hazard_src_match
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int NUM_SRC  = 2,
   parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
   input  logic                     mem_read,
   input  logic [REG_W-1:0]         rd,
   input  logic [NUM_SRC*REG_W-1:0] src,
   input  logic [NUM_SRC-1:0]       src_valid,
   output logic                     hazard
);

   logic [NUM_SRC-1:0] match;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      assign match[k] = src_valid[k] && (src[k*REG_W +: REG_W] == rd);
   end

   assign hazard = mem_read && (rd != REG_W'(ZERO_REG)) && (|match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller beside ID: load-use bubbles, memory freeze,
// branch flush and a saturating count of cycles the PC was held.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int ZERO_REG = ZERO_REG_DEFAULT,
   parameter int CNT_W    = 32
) (
   input logic          clk,
   input logic          reset,
   hazard_stall_ctrl_if.slave bus
);

   localparam int REM_W = $clog2(LOAD_LAT + 1);

   hz_state_e        state, state_next;
   logic [REM_W-1:0] rem, rem_next;
   logic             hazard;
   logic             freeze;
   logic             pc_we, exmem_we;
   stage_ctrl_t      ifid_c, idex_c;
   logic [CNT_W-1:0] stall_cnt;

   hazard_src_match #(
      .REG_W    (REG_W),
      .NUM_SRC  (NUM_SRC),
      .ZERO_REG (ZERO_REG)
   ) u_match (
      .mem_read  (bus.idex_mem_read),
      .rd        (bus.idex_rd),
      .src       (bus.ifid_src),
      .src_valid (bus.ifid_src_valid),
      .hazard    (hazard)
   );

   assign freeze = bus.mem_req && !bus.mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HZ_RUN;
         rem   <= '0;
      end else begin
         state <= state_next;
         rem   <= rem_next;
      end
   end

   // A memory freeze overrides everything and holds state; a bubble stall keeps
   // PC and IF/ID while ID/EX takes a bubble and the older stages keep moving.
   always_comb begin
      state_next = state;
      rem_next   = rem;
      pc_we      = 1'b1;
      exmem_we   = 1'b1;
      ifid_c     = STAGE_RUN;
      idex_c     = STAGE_RUN;
      if (!reset) begin
         if (freeze) begin
            pc_we    = 1'b0;
            exmem_we = 1'b0;
            ifid_c   = '{write_en: 1'b0, flush: 1'b0};
            idex_c   = '{write_en: 1'b0, flush: 1'b0};
         end else begin
            unique case (state)
               HZ_RUN: begin
                  if (bus.branch_taken) begin
                     ifid_c.flush = 1'b1;
                     idex_c.flush = 1'b1;
                  end else if (hazard) begin
                     pc_we           = 1'b0;
                     ifid_c.write_en = 1'b0;
                     idex_c.flush    = 1'b1;
                     if (LOAD_LAT > 1) begin
                        state_next = HZ_LOAD_STALL;
                        rem_next   = REM_W'(LOAD_LAT - 1);
                     end
                  end
               end
               HZ_LOAD_STALL: begin
                  pc_we           = 1'b0;
                  ifid_c.write_en = 1'b0;
                  idex_c.flush    = 1'b1;
                  rem_next        = rem - REM_W'(1);
                  if (rem == REM_W'(1)) begin
                     state_next = HZ_RUN;
                  end
               end
               default: state_next = HZ_RUN;
            endcase
         end
      end
   end

   // Saturates rather than wraps so long-running stall statistics stay monotonic.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign bus.pc_write_en    = pc_we;
   assign bus.ifid_write_en  = ifid_c.write_en;
   assign bus.ifid_flush     = ifid_c.flush;
   assign bus.idex_write_en  = idex_c.write_en;
   assign bus.idex_flush     = idex_c.flush;
   assign bus.exmem_write_en = exmem_we;
   assign bus.stall_cycles   = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three configurations driven by one directed
// stimulus stream, checked every cycle against a bubble-count model.
module tb_hazard_stall_ctrl;

   typedef struct packed {
      logic pc;
      logic ifid_we;
      logic idex_we;
      logic exmem_we;
      logic ifid_fl;
      logic idex_fl;
   } ctl_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       mem_read;
   logic [4:0] rd;
   logic [4:0] src [3];
   logic [2:0] src_valid;
   logic       branch;
   logic       mem_req;
   logic       mem_ready;

   int     errors = 0;
   int     checks = 0;
   bit     run_checks = 1'b0;

   // Model configuration: A = LOAD_LAT 1 / 2 srcs, B = LOAD_LAT 3 / 3 srcs, C = LOAD_LAT 3 / 2 srcs / 4-bit counter
   int     lat  [3] = '{1, 3, 3};
   int     nsrc [3] = '{2, 3, 2};
   longint cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
   int     pending [3];
   longint cnt [3];

   always #5 clk = ~clk;

   hazard_stall_ctrl_if #(.REG_W(5), .NUM_SRC(2), .CNT_W(32)) if_a ();
   hazard_stall_ctrl_if #(.REG_W(5), .NUM_SRC(3), .CNT_W(32)) if_b ();
   hazard_stall_ctrl_if #(.REG_W(5), .NUM_SRC(2), .CNT_W(4))  if_c ();

   assign if_a.idex_mem_read  = mem_read;
   assign if_a.idex_rd        = rd;
   assign if_a.ifid_src       = {src[1], src[0]};
   assign if_a.ifid_src_valid = src_valid[1:0];
   assign if_a.branch_taken   = branch;
   assign if_a.mem_req        = mem_req;
   assign if_a.mem_ready      = mem_ready;

   assign if_b.idex_mem_read  = mem_read;
   assign if_b.idex_rd        = rd;
   assign if_b.ifid_src       = {src[2], src[1], src[0]};
   assign if_b.ifid_src_valid = src_valid;
   assign if_b.branch_taken   = branch;
   assign if_b.mem_req        = mem_req;
   assign if_b.mem_ready      = mem_ready;

   assign if_c.idex_mem_read  = mem_read;
   assign if_c.idex_rd        = rd;
   assign if_c.ifid_src       = {src[1], src[0]};
   assign if_c.ifid_src_valid = src_valid[1:0];
   assign if_c.branch_taken   = branch;
   assign if_c.mem_req        = mem_req;
   assign if_c.mem_ready      = mem_ready;

   hazard_stall_ctrl #(.REG_W(5), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG(31), .CNT_W(32)) dut_a (
      .clk (clk), .reset (reset), .bus (if_a)
   );
   hazard_stall_ctrl #(.REG_W(5), .NUM_SRC(3), .LOAD_LAT(3), .ZERO_REG(31), .CNT_W(32)) dut_b (
      .clk (clk), .reset (reset), .bus (if_b)
   );
   hazard_stall_ctrl #(.REG_W(5), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG(31), .CNT_W(4)) dut_c (
      .clk (clk), .reset (reset), .bus (if_c)
   );

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit model_hazard(int d);
      bit hit = 1'b0;
      for (int k = 0; k < nsrc[d]; k++) begin
         if (src_valid[k] && src[k] == rd) hit = 1'b1;
      end
      return mem_read && (rd != 5'd31) && hit;
   endfunction

   // Expected controls: a pending bubble or a fresh hazard stalls, a freeze holds everything
   function automatic ctl_t model_ctl(int d);
      ctl_t c = 6'b111100;
      if (reset) return c;
      if (mem_req && !mem_ready)  c = 6'b000000;
      else if (pending[d] > 0)    c = 6'b001101;
      else if (branch)            c = 6'b111111;
      else if (model_hazard(d))   c = 6'b001101;
      return c;
   endfunction

   function automatic ctl_t dut_ctl(int d);
      ctl_t c;
      case (d)
         0:       c = {if_a.pc_write_en, if_a.ifid_write_en, if_a.idex_write_en,
                       if_a.exmem_write_en, if_a.ifid_flush, if_a.idex_flush};
         1:       c = {if_b.pc_write_en, if_b.ifid_write_en, if_b.idex_write_en,
                       if_b.exmem_write_en, if_b.ifid_flush, if_b.idex_flush};
         default: c = {if_c.pc_write_en, if_c.ifid_write_en, if_c.idex_write_en,
                       if_c.exmem_write_en, if_c.ifid_flush, if_c.idex_flush};
      endcase
      return c;
   endfunction

   function automatic longint dut_cnt(int d);
      case (d)
         0:       return longint'(if_a.stall_cycles);
         1:       return longint'(if_b.stall_cycles);
         default: return longint'(if_c.stall_cycles);
      endcase
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         ctl_t c;
         c = model_ctl(d);
         if (reset) begin
            pending[d] = 0;
            cnt[d]     = 0;
         end else begin
            assert (!(pending[d] > 0 && branch && !(mem_req && !mem_ready)))
               else $error("[TB] branch_taken during load stall in config %0d", d);
            if (!c.pc && cnt[d] < cmax[d]) cnt[d]++;
            if (!(mem_req && !mem_ready)) begin
               if (pending[d] > 0)                      pending[d]--;
               else if (!branch && model_hazard(d))     pending[d] = lat[d] - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run_checks) begin
         for (int d = 0; d < 3; d++) begin
            ctl_t e, a;
            e = model_ctl(d);
            a = dut_ctl(d);
            checkOutput($sformatf("pc_write_en[%0d]", d),    a.pc,       e.pc);
            checkOutput($sformatf("ifid_write_en[%0d]", d),  a.ifid_we,  e.ifid_we);
            checkOutput($sformatf("idex_write_en[%0d]", d),  a.idex_we,  e.idex_we);
            checkOutput($sformatf("exmem_write_en[%0d]", d), a.exmem_we, e.exmem_we);
            checkOutput($sformatf("ifid_flush[%0d]", d),     a.ifid_fl,  e.ifid_fl);
            checkOutput($sformatf("idex_flush[%0d]", d),     a.idex_fl,  e.idex_fl);
            checkOutput($sformatf("stall_cycles[%0d]", d),   dut_cnt(d), cnt[d]);
         end
      end
   end

   task automatic applyStimulus(input logic rst, input logic mr, input logic [4:0] r,
                                input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [2:0] v, input logic br, input logic mq, input logic mrdy);
      reset     = rst;
      mem_read  = mr;
      rd        = r;
      src[0]    = s0;
      src[1]    = s1;
      src[2]    = s2;
      src_valid = v;
      branch    = br;
      mem_req   = mq;
      mem_ready = mrdy;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic freezeCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic loadUse();
      applyStimulus(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      run_checks = 1'b1;
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1);
      checkOutput("reset_pc_a", if_a.pc_write_en, 1);
      checkOutput("reset_ifid_flush_a", if_a.ifid_flush, 0);
      nextCycle();
      nextCycle();
      idle();
      checkOutput("reset_cnt_b", if_b.stall_cycles, 0);
      nextCycle();

      // Single load-use hazard: A stalls once, B and C stall three times
      loadUse();
      checkOutput("lu_pc_a", if_a.pc_write_en, 0);
      checkOutput("lu_ifid_we_a", if_a.ifid_write_en, 0);
      checkOutput("lu_idex_flush_a", if_a.idex_flush, 1);
      checkOutput("lu_idex_we_a", if_a.idex_write_en, 1);
      nextCycle();
      idle();
      checkOutput("lu_after_pc_a", if_a.pc_write_en, 1);
      checkOutput("lu_cnt_a", if_a.stall_cycles, 1);
      checkOutput("lu_stall2_pc_b", if_b.pc_write_en, 0);
      nextCycle();
      idle();
      checkOutput("lu_stall3_pc_b", if_b.pc_write_en, 0);
      nextCycle();
      idle();
      checkOutput("lu_done_pc_b", if_b.pc_write_en, 1);
      checkOutput("lu_cnt_b", if_b.stall_cycles, 3);
      nextCycle();

      // Masked operand and zero register never stall
      applyStimulus(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1);
      checkOutput("masked_pc_b", if_b.pc_write_en, 1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 5'd31, 3'b111, 1'b0, 1'b0, 1'b1);
      checkOutput("zero_reg_pc_b", if_b.pc_write_en, 1);
      nextCycle();

      // Match only on operand 2: only the three-source configuration sees it
      applyStimulus(1'b0, 1'b1, 5'd7, 5'd1, 5'd2, 5'd7, 3'b111, 1'b0, 1'b0, 1'b1);
      checkOutput("op2_pc_a", if_a.pc_write_en, 1);
      checkOutput("op2_pc_b", if_b.pc_write_en, 0);
      checkOutput("op2_pc_c", if_c.pc_write_en, 1);
      nextCycle();
      idle();
      nextCycle();
      idle();
      nextCycle();
      applyStimulus(1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 5'd7, 3'b111, 1'b0, 1'b0, 1'b1);
      checkOutput("no_load_pc_b", if_b.pc_write_en, 1);
      checkOutput("op2_cnt_b", if_b.stall_cycles, 6);
      nextCycle();

      // Freeze of two cycles in the middle of a three-bubble stall
      loadUse();
      nextCycle();
      idle();
      nextCycle();
      freezeCycle();
      checkOutput("frz_exmem_we_b", if_b.exmem_write_en, 0);
      checkOutput("frz_idex_flush_b", if_b.idex_flush, 0);
      checkOutput("frz_pc_a", if_a.pc_write_en, 0);
      nextCycle();
      freezeCycle();
      nextCycle();
      idle();
      checkOutput("frz_last_bubble_b", if_b.idex_flush, 1);
      nextCycle();
      idle();
      checkOutput("frz_done_pc_b", if_b.pc_write_en, 1);
      checkOutput("frz_cnt_b", if_b.stall_cycles, 11);
      checkOutput("frz_cnt_c", if_c.stall_cycles, 8);
      checkOutput("frz_cnt_a", if_a.stall_cycles, 4);
      nextCycle();

      // Branch beats a simultaneous hazard
      applyStimulus(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0, 1'b1);
      checkOutput("br_pc_b", if_b.pc_write_en, 1);
      checkOutput("br_ifid_flush_b", if_b.ifid_flush, 1);
      checkOutput("br_idex_flush_b", if_b.idex_flush, 1);
      nextCycle();
      idle();
      checkOutput("br_no_stall_b", if_b.pc_write_en, 1);
      nextCycle();

      // Reset aborts a stall in progress
      loadUse();
      nextCycle();
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_mid_pc_b", if_b.pc_write_en, 1);
      nextCycle();
      idle();
      checkOutput("rst_after_pc_b", if_b.pc_write_en, 1);
      checkOutput("rst_after_cnt_b", if_b.stall_cycles, 0);
      nextCycle();

      // Long freeze saturates the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         freezeCycle();
         nextCycle();
      end
      idle();
      checkOutput("sat_cnt_c", if_c.stall_cycles, 15);
      checkOutput("sat_cnt_a", if_a.stall_cycles, 20);
      nextCycle();
      idle();
      checkOutput("sat_hold_cnt_c", if_c.stall_cycles, 15);
      nextCycle();

      @(negedge clk);
      #1;
      run_checks = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
